sha1_block_feeder: RTL and testbench
====================================

# sha1_block_feeder

Source side of the SHA-1 round pipeline. Accepts a big-endian message as a stream of 32-bit words, applies SHA-1 padding (0x80 marker, zero fill, 64-bit bit length), buffers complete 512-bit blocks, and drives the round pipeline at one round per clock. Per 80-round block it presents 16 message words with a load strobe and issues the four round-group phase advances.

## Interface
- No parameters.
- `clk` input 1: clock; all logic on posedge.
- `rst_n` input 1: synchronous reset, active-low.
- `in_data` input 32: message word, first byte in bits [31:24].
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: word accepted when `in_valid && in_ready`.
- `in_last` input 1: final word of the message.
- `in_bytes` input 3: valid bytes in the final word, 0..4. Sampled only with `in_last`. 0 is legal only for an empty message; unused bytes are ignored.
- `Din` output 32: message word, meaningful while `load6` is high.
- `load6` output 1: high on rounds 0..15 of each block.
- `phase_advance7` output 1: round-group advance, one cycle ahead of the group boundary.
- `blk_first` output 1: high on round 0 of the message's first block.
- `blk_final` output 1: high on round 0 of the message's last block.
- `msg_done` output 1: one-cycle pulse on the cycle after round 79 of the final block.

## Operation
- Fill FSM states:
  - FILL: accepts words into the fill buffer at word index `wi` (0..15).
  - MARK: writes 0x80000000 when the last word was full.
  - ZERO: zero words.
  - LENHI / LENLO: bit count [63:32] and [31:0].
  - HOLD: waits for a free buffer.
- Last word handling:
  - `in_bytes` = 1..3: bytes beyond `in_bytes` are replaced by 0x80 followed by zeros.
  - `in_bytes` = 4 or 0: MARK follows. For 0, nothing is counted.
- After the marker, ZERO fills until `wi` = 14, then LENHI and LENLO.
- If the marker lands at `wi` ≥ 14, ZERO runs to `wi` = 15. The block closes, and a second block of 14 zeros plus the length follows.
- Bit count is a 64-bit counter: +32 per full word, +8·`in_bytes` on the last word. It clears at the start of each message. Wrap is modulo 2^64.
- Pad words are written one per cycle with no input consumed. `in_ready` is low from the cycle after `in_last` is accepted until the next message may start.
- When a block completes, the fill buffer is marked full. `in_ready` drops if no empty buffer remains.
- Stream side:
  - A 7-bit round counter `r` runs 0..79 while a full buffer exists.
  - `Din` = word[`r`] and `load6` = 1 for `r` ≤ 15.
  - At `r` = 79 the buffer is released. If another buffer is full, the next block's round 0 follows immediately; otherwise the stream idles with `load6` = 0.
- `phase_advance7` is high on cycles with `r` = 19, 39 or 59. It is also high on the cycle preceding any round 0 (either `r` = 79 with a full buffer pending, or idle with a full buffer pending).
- `blk_first` and `blk_final` are flags stored with each buffer.
- Reset mid-message: buffers are emptied, counters cleared, the message is discarded, and no `msg_done` is issued.

## Timing
- Reset values:
  - `in_ready` = 0 during reset, 1 on the first cycle after reset.
  - `load6`, `phase_advance7`, `blk_first`, `blk_final`, `msg_done` = 0.
  - `Din` = 0.
- All outputs are registered.
- Latency from the 16th word of a block being written (data or pad) to that block's round 0 is 2 cycles when the stream is idle: a one-cycle `phase_advance7` precedes round 0.
- Minimum block period is 80 cycles. Sustained input rate is 16 words per 80 cycles when double buffered.
- Simultaneous release at `r` = 79 and fill completion: the freed buffer is available to FILL on the next cycle.

## Configuration
- `SHA1_FEED_DOUBLE_BUF_EN` defined: two 16-word buffers in ping-pong, so filling overlaps streaming and blocks run back-to-back.
- `SHA1_FEED_DOUBLE_BUF_EN` undefined: single buffer. `in_ready` and pad writes stall from block completion until release at `r` = 79, giving at least 1 idle cycle between blocks.

## Test plan
- "abc": one word 0x61626300 with `in_last` and `in_bytes`=3.
  - Required: `Din` = 0x61626380, then 14×0, then 0x00000018.
  - `blk_first` = `blk_final` = 1, and `msg_done` 80 cycles after round 0.
- Empty message: `in_bytes`=0 with `in_last`.
  - Required: `Din` = 0x80000000, 14×0, 0x00000000.
- 56 bytes (14 full words):
  - Block 1: words 0..13 as input, W14 = 0x80000000, W15 = 0.
  - Block 2: 14×0, 0, 0x000001C0, with `blk_final` only on block 2.
- 55 bytes (last word `in_bytes`=3): single block with W13 low byte 0x80 and W15 = 0x000001B8.
- Timing: `phase_advance7` at r=19/39/59 and before each round 0.
  - With the macro: 32 words streamed with `in_valid` always high give back-to-back blocks with 0 idle cycles.
  - Without the macro: `in_ready` is low during streaming.
- Assert `rst_n` low at r=40 of block 1 of a 3-block message.
  - Required: all outputs 0 next cycle, no `msg_done`, and a fresh "abc" afterward is correct.

Source files
------------

// File: rtl/sha1_block_feeder.sv
// SHA-1 block feeder: pads a big-endian 32-bit word stream into 512-bit blocks and streams them
// at one round per clock. Define SHA1_FEED_DOUBLE_BUF_EN for ping-pong buffering (default: single).
module sha1_block_feeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic [31:0] Din,
    output logic        load6,
    output logic        phase_advance7,
    output logic        blk_first,
    output logic        blk_final,
    output logic        msg_done
);
`ifdef SHA1_FEED_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef enum logic [2:0] {FILL, MARK, ZERO, LENHI, LENLO, HOLD} fill_state_t;
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN} stream_state_t;

    // Both buffers always exist; in single-buffer builds buffer 1 is never selected.
    logic [31:0]   mem [2][16];
    logic [1:0]    full, full_d, first_f, final_f, avail;
    fill_state_t   state, state_d, ret, ret_d, pad_next;
    logic          fb, fb_d;
    logic [3:0]    wi;
    logic [63:0]   bit_cnt, bit_cnt_d;
    logic          first_pend, first_pend_d;
    logic [5:0]    last_bits;
    logic          accept, wr_en, complete, release_en, last_blk;
    logic [31:0]   wr_data;

    stream_state_t ss, ss_d;
    logic [6:0]    r, r_d;
    logic          rb, rb_d;
    logic          pa7_d, load_d;

    assign accept = in_valid && in_ready;

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        release_en   = (ss == S_RUN) && (r == 7'd79);
        avail[0]     = !full[0] || (release_en && !rb);
        avail[1]     = !full[1] || (release_en && rb);
        last_bits    = (in_bytes >= 3'd4) ? 6'd32 : {1'b0, in_bytes[1:0], 3'b000};
        pad_next     = (wi == 4'd13) ? LENHI : ZERO;
        wr_en        = 1'b0;
        wr_data      = '0;
        last_blk     = 1'b0;
        state_d      = state;
        ret_d        = ret;
        bit_cnt_d    = bit_cnt;
        first_pend_d = first_pend;

        case (state)
            FILL: if (accept) begin
                if (!in_last) begin
                    wr_en     = 1'b1;
                    wr_data   = in_data;
                    bit_cnt_d = bit_cnt + 64'd32;
                end else begin
                    bit_cnt_d = bit_cnt + {58'd0, last_bits};
                    wr_en     = (in_bytes != 3'd0);
                    state_d   = pad_next;
                    // A partial last word carries its own 0x80 marker.
                    case (in_bytes)
                        3'd0:    state_d = MARK;
                        3'd1:    wr_data = {in_data[31:24], 24'h80_0000};
                        3'd2:    wr_data = {in_data[31:16], 16'h8000};
                        3'd3:    wr_data = {in_data[31:8], 8'h80};
                        default: begin
                            wr_data = in_data;
                            state_d = MARK;
                        end
                    endcase
                end
            end
            MARK: begin
                wr_en   = 1'b1;
                wr_data = 32'h8000_0000;
                state_d = pad_next;
            end
            ZERO: begin
                wr_en   = 1'b1;
                state_d = pad_next;
            end
            LENHI: begin
                wr_en   = 1'b1;
                wr_data = bit_cnt[63:32];
                state_d = LENLO;
            end
            LENLO: begin
                wr_en     = 1'b1;
                wr_data   = bit_cnt[31:0];
                last_blk  = 1'b1;
                bit_cnt_d = '0;
                state_d   = FILL;
            end
            HOLD:    if (avail[fb]) state_d = ret;
            default: state_d = FILL;
        endcase

        complete = wr_en && (wi == 4'd15);
        fb_d     = complete ? (fb ^ DBL) : fb;
        if (complete) begin
            first_pend_d = last_blk;
            if (!(DBL && avail[~fb])) begin
                ret_d   = state_d;
                state_d = HOLD;
            end
        end

        full_d = full;
        if (release_en) full_d[rb] = 1'b0;
        if (complete)   full_d[fb] = 1'b1;
    end

    always_comb begin
        ss_d = ss;
        r_d  = r;
        rb_d = rb;
        case (ss)
            S_IDLE: if (full[rb]) ss_d = S_PRE;
            S_PRE: begin
                ss_d = S_RUN;
                r_d  = '0;
            end
            S_RUN: begin
                if (r == 7'd79) begin
                    rb_d = rb ^ DBL;
                    if (DBL && full[~rb]) r_d = '0;
                    else                  ss_d = S_IDLE;
                end else begin
                    r_d = r + 7'd1;
                end
            end
            default: ss_d = S_IDLE;
        endcase

        // Outputs are registered from the next stream state so they line up with the round.
        load_d = (ss_d == S_RUN) && (r_d < 7'd16);
        pa7_d  = (ss_d == S_PRE) ||
                 ((ss_d == S_RUN) && ((r_d == 7'd19) || (r_d == 7'd39) || (r_d == 7'd59) ||
                                      ((r_d == 7'd79) && DBL && full_d[~rb_d])));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= FILL;
            ret            <= FILL;
            wi             <= '0;
            fb             <= 1'b0;
            full           <= '0;
            first_f        <= '0;
            final_f        <= '0;
            bit_cnt        <= '0;
            first_pend     <= 1'b1;
            in_ready       <= 1'b0;
            ss             <= S_IDLE;
            r              <= '0;
            rb             <= 1'b0;
            Din            <= '0;
            load6          <= 1'b0;
            phase_advance7 <= 1'b0;
            blk_first      <= 1'b0;
            blk_final      <= 1'b0;
            msg_done       <= 1'b0;
        end else begin
            state      <= state_d;
            ret        <= ret_d;
            fb         <= fb_d;
            full       <= full_d;
            bit_cnt    <= bit_cnt_d;
            first_pend <= first_pend_d;
            in_ready   <= (state_d == FILL) && !full_d[fb_d];
            if (wr_en) wi <= wi + 4'd1;
            if (complete) begin
                first_f[fb] <= first_pend;
                final_f[fb] <= last_blk;
            end
            ss             <= ss_d;
            r              <= r_d;
            rb             <= rb_d;
            load6          <= load_d;
            Din            <= load_d ? mem[rb_d][r_d[3:0]] : 32'd0;
            phase_advance7 <= pa7_d;
            blk_first      <= (ss_d == S_RUN) && (r_d == 7'd0) && first_f[rb_d];
            blk_final      <= (ss_d == S_RUN) && (r_d == 7'd0) && final_f[rb_d];
            msg_done       <= release_en && final_f[rb];
        end
    end

    // NOTE: buffer storage is not reset; a word is only streamed after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[fb][wi] <= wr_data;
    end

endmodule

// File: tb/tb_sha1_block_feeder.sv
// Bench for sha1_block_feeder: a byte-level SHA-1 padding model fills an expected-word queue;
// a negedge monitor pops and compares every streamed word, flag, phase advance and msg_done.
`timescale 1ns/1ps
module tb_sha1_block_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic [31:0] Din;
    logic        load6, phase_advance7, blk_first, blk_final, msg_done;

    always #5 clk = ~clk;

    sha1_block_feeder dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_bytes(in_bytes), .Din(Din), .load6(load6),
        .phase_advance7(phase_advance7), .blk_first(blk_first), .blk_final(blk_final),
        .msg_done(msg_done)
    );

    typedef struct packed {
        logic        start;
        logic        first;
        logic        fin;
        logic [31:0] word;
    } exp_t;
    typedef byte unsigned bytes_t[$];

    exp_t   exp_q[$];
    int     done_q[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    bit     abort = 1'b0;
    bit     expect_b2b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic model(input bytes_t m);
        bytes_t      p;
        logic [63:0] bits;
        int          nblk;
        exp_t        e;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 16; w++) begin
                e.start = (w == 0);
                e.first = (b == 0);
                e.fin   = (b == nblk - 1);
                e.word  = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
                exp_q.push_back(e);
            end
        end
        done_q.push_back(nblk);
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int waited;
        waited   = 0;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        while (!in_ready && !abort) begin
            @(negedge clk);
            waited++;
            if (waited > 3000) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                abort = 1'b1;
            end
        end
        if (!abort) @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Unused bytes of the last word are random so that the bench sees them ignored.
    task automatic send_msg(input bytes_t m, input int gap_max);
        int          nw;
        int          nb;
        logic [31:0] d;
        model(m);
        if (m.size() == 0) begin
            send_word($urandom, 1'b1, 3'd0);
            return;
        end
        nw = (m.size() + 3) / 4;
        for (int w = 0; w < nw && !abort; w++) begin
            d  = $urandom;
            nb = m.size() - 4 * w;
            if (nb > 4) nb = 4;
            for (int k = 0; k < nb; k++) d[31-8*k -: 8] = m[4*w+k];
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            send_word(d, (w == nw - 1), 3'(nb));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(t < 5000), 64'd1);
        exp_q.delete();
        done_q.delete();
        repeat (4) @(negedge clk);
    endtask

    // Monitor: rc tracks the round being presented, -1 while the stream is idle.
    int     rc = -1;
    logic   prev_pa7 = 1'b0;
    longint final_r0 = -1;
    always @(negedge clk) begin
        bit   round0;
        exp_t e;
        if (!rst_n) begin
            rc       = -1;
            prev_pa7 = 1'b0;
        end else begin
            round0 = load6 && (rc < 0 || rc >= 79);
            check("phase_advance7", 64'(prev_pa7),
                  64'((rc == 19) || (rc == 39) || (rc == 59) || round0));
            if (round0) begin
`ifdef SHA1_FEED_DOUBLE_BUF_EN
                if (expect_b2b && exp_q.size() > 0 && !exp_q[0].first)
                    check("b2b_gap", 64'(rc), 64'd79);
`else
                check("idle_gap", 64'(rc == 79), 64'd0);
`endif
                rc = 0;
            end else if (rc >= 0) begin
                rc = (rc == 79) ? -1 : rc + 1;
            end
            if (load6) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {round0, blk_first, blk_final, Din},
                          {e.start, e.start & e.first, e.start & e.fin, e.word});
                    if (round0 && e.fin) final_r0 = cyc;
                end
            end else begin
                check("flags_idle", {blk_first, blk_final}, 64'd0);
                if (rc >= 0 && rc <= 15) check("load6_gap", 64'd0, 64'd1);
            end
`ifndef SHA1_FEED_DOUBLE_BUF_EN
            if (rc >= 0) check("in_ready_stream", 64'(in_ready), 64'd0);
`endif
            if (msg_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_msg_done", 64'd1, 64'd0);
                end else begin
                    void'(done_q.pop_front());
                    check("msg_done_latency", 64'(cyc - final_r0), 64'd80);
                end
            end
            prev_pa7 = phase_advance7;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t m;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        abort    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {in_ready, load6, phase_advance7, blk_first, blk_final, msg_done, Din}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        drain();
        m = {};
        send_msg(m, 0);
        drain();
        send_msg(rand_bytes(56), 0);
        drain();
        send_msg(rand_bytes(55), 2);
        drain();
        repeat (6) send_msg(rand_bytes($urandom_range(150, 0)), 3);
        drain();

        expect_b2b = 1'b1;
        send_msg(rand_bytes(128), 0);
        drain();
        expect_b2b = 1'b0;

        // Reset at round 40 of the first block of a three-block message.
        m = rand_bytes(160);
        fork
            send_msg(m, 0);
            begin
                int t;
                t = 0;
                while (!(load6 && blk_first) && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                check("reset_test_start", 64'(t < 3000), 64'd1);
                repeat (40) @(negedge clk);
                abort = 1'b1;
                rst_n = 1'b0;
                @(negedge clk);
                check("outputs_after_mid_reset",
                      {load6, phase_advance7, blk_first, blk_final, msg_done, Din}, 64'd0);
                @(negedge clk);
                exp_q.delete();
                done_q.delete();
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (150) @(negedge clk);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
